// File: rtl/adler_pkg.sv
// Shared Adler-32 definitions for the checksum generator and checker.
package adler_pkg;

  localparam logic [15:0] ADLER_MOD    = 16'd65521;
  localparam logic [15:0] ADLER_A_INIT = 16'd1;
  localparam logic [15:0] ADLER_B_INIT = 16'd0;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    WAIT_CHK,
    REPORT
  } adler_state_e;

endpackage

// File: rtl/adler_mod_add.sv
// Combinational (a + b) mod MOD for operands already reduced below MOD.
// The 17-bit sum is below 2*MOD, so one conditional subtract is enough.
module adler_mod_add
  import adler_pkg::*;
#(
  parameter int unsigned MOD = 32'(ADLER_MOD)
) (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  localparam logic [16:0] MOD17 = 17'(MOD);

  logic [16:0] sum;

  // Add, then fold back into range with a single subtract.
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    y   = (sum >= MOD17) ? 16'(sum - MOD17) : sum[15:0];
  end

endmodule

// File: rtl/adler_checksum_checker.sv
// Adler-32 receive-side checker: accumulates a byte frame, accepts the
// transmitted checksum, and reports pass/fail with a one-cycle done pulse.
// Optional pass/fail counters are built when ADLER_STATUS_CNT_EN is defined.
module adler_checksum_checker
  import adler_pkg::*;
#(
  parameter int unsigned MOD   = 32'(ADLER_MOD),
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic [31:0] chk_data,
  input  logic        chk_valid,
  output logic        chk_ready,
  output logic        done,
  output logic        pass,
  output logic [31:0] calc_sum
`ifdef ADLER_STATUS_CNT_EN
  ,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
`endif
);

  // Reject configurations the 16-bit datapath cannot represent.
  if (MOD < 2 || MOD > 65535 || CNT_W < 1) begin : g_param_err
    $error("adler_checksum_checker: MOD must be in [2,65535] and CNT_W >= 1");
  end

  adler_state_e state_q, state_d;
  logic [15:0]  a_q, a_d;
  logic [15:0]  b_q, b_d;
  logic         pass_q, pass_d;
  logic [31:0]  calc_q, calc_d;
  logic         in_ready_q, in_ready_d;
  logic         chk_ready_q, chk_ready_d;
  logic         done_q, done_d;

  logic [15:0]  a_next;
  logic [15:0]  b_next;
  logic         byte_acc;
  logic         chk_acc;

  // A path: A + byte; B path uses the freshly updated A.
  adler_mod_add #(.MOD(MOD)) u_add_a (
    .a (a_q),
    .b ({8'h00, in_data}),
    .y (a_next)
  );

  adler_mod_add #(.MOD(MOD)) u_add_b (
    .a (b_q),
    .b (a_next),
    .y (b_next)
  );

  assign byte_acc = in_valid & in_ready_q;
  assign chk_acc  = chk_valid & chk_ready_q;

  // Next-state and datapath updates; clr overrides any handshake.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    calc_d  = calc_q;

    if (clr) begin
      state_d = IDLE;
      a_d     = ADLER_A_INIT;
      b_d     = ADLER_B_INIT;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (byte_acc) begin
            a_d     = a_next;
            b_d     = b_next;
            state_d = in_last ? WAIT_CHK : ACCUM;
          end
        end
        WAIT_CHK: begin
          if (chk_acc) begin
            calc_d  = {b_q, a_q};
            pass_d  = (chk_data == {b_q, a_q});
            a_d     = ADLER_A_INIT;
            b_d     = ADLER_B_INIT;
            state_d = REPORT;
          end
        end
        REPORT: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Handshake and done outputs are registered copies of the next state decode,
  // so they always reflect the state held during the current cycle.
  always_comb begin
    in_ready_d  = (state_d == IDLE) || (state_d == ACCUM);
    chk_ready_d = (state_d == WAIT_CHK);
    done_d      = (state_d == REPORT);
  end

  // State, accumulators and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= ADLER_A_INIT;
      b_q         <= ADLER_B_INIT;
      pass_q      <= 1'b0;
      calc_q      <= '0;
      in_ready_q  <= 1'b1;
      chk_ready_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      pass_q      <= pass_d;
      calc_q      <= calc_d;
      in_ready_q  <= in_ready_d;
      chk_ready_q <= chk_ready_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign chk_ready = chk_ready_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign calc_sum  = calc_q;

`ifdef ADLER_STATUS_CNT_EN
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

  // One saturating counter steps per done pulse, chosen by the held result.
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (done_q) begin
      if (pass_q) begin
        if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 1'b1;
      end else begin
        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
      end
    end
  end

  // Counters are cleared only by reset, never by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_adler_checksum_checker.sv
// Directed testbench for adler_checksum_checker. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_adler_checksum_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] chk_data = '0;
  logic        chk_valid = 1'b0;
  logic        chk_ready;
  logic        done;
  logic        pass;
  logic [31:0] calc_sum;
`ifdef ADLER_STATUS_CNT_EN
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  logic [7:0] frame_q[$];
  logic [7:0] wiki[9] = '{8'h57, 8'h69, 8'h6B, 8'h69, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};

  adler_checksum_checker #(.MOD(65521), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .chk_data  (chk_data),
    .chk_valid (chk_valid),
    .chk_ready (chk_ready),
    .done      (done),
    .pass      (pass),
    .calc_sum  (calc_sum)
`ifdef ADLER_STATUS_CNT_EN
    ,
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Sends frame_q one byte per cycle; in_last on the final byte if end_frame.
  task automatic send_frame(input bit end_frame);
    for (int i = 0; i < frame_q.size(); i++) begin
      int n;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frame_q[i];
      in_last  = end_frame && (i == frame_q.size() - 1);
      n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        n_cmp++; n_err++;
        $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Presents a checksum and returns at the falling edge of the REPORT cycle.
  task automatic send_chk(input logic [31:0] v);
    int n;
    @(negedge clk);
    chk_valid = 1'b1;
    chk_data  = v;
    n = 0;
    while (chk_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL chk_ready_timeout: chk_ready=%b required 1", chk_ready);
    end
    @(negedge clk);
    chk_valid = 1'b0;
  endtask

  task automatic load_wiki();
    frame_q = {};
    foreach (wiki[i]) frame_q.push_back(wiki[i]);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (chk_ready !== 1'b0) begin n_err++; $display("FAIL reset_chk_ready: got %b want 0", chk_ready); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL reset_pass: got %b want 0", pass); end
    n_cmp++; if (calc_sum !== 32'h0) begin n_err++; $display("FAIL reset_calc_sum: got %h want 00000000", calc_sum); end
`ifdef ADLER_STATUS_CNT_EN
    n_cmp++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin n_err++; $display("FAIL reset_counters: got %0d/%0d want 0/0", pass_cnt, fail_cnt); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_wikipedia();
    int d0;
    load_wiki();
    d0 = done_cnt;
    send_frame(1'b1);
    send_chk(32'h11E60398);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL wiki_done: got %b want 1", done); end
    n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL wiki_pass: got %b want 1", pass); end
    n_cmp++; if (calc_sum !== 32'h11E60398) begin n_err++; $display("FAIL wiki_calc: got %h want 11e60398", calc_sum); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL wiki_done_width: got %b want 0", done); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL wiki_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_wiki_bad();
    load_wiki();
    send_frame(1'b1);
    send_chk(32'h11E60399);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL bad_done: got %b want 1", done); end
    n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL bad_pass: got %b want 0", pass); end
    n_cmp++; if (calc_sum !== 32'h11E60398) begin n_err++; $display("FAIL bad_calc: got %h want 11e60398", calc_sum); end
  endtask

  task automatic test_clr();
    int d0;
    // Abort mid-frame; previous failing result must be held.
    frame_q = {8'h57, 8'h69, 8'h6B};
    send_frame(1'b0);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL clr_pass_hold: got %b want 0", pass); end
    n_cmp++; if (calc_sum !== 32'h11E60398) begin n_err++; $display("FAIL clr_calc_hold: got %h want 11e60398", calc_sum); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL clr_in_ready: got %b want 1", in_ready); end
    d0 = done_cnt;
    load_wiki();
    send_frame(1'b1);
    send_chk(32'h11E60398);
    @(negedge clk);
    n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL clr_full_pass: got %b want 1", pass); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL clr_done_count: got %0d want 1", done_cnt - d0); end
    // clr together with a checksum handshake: clr wins, no done.
    frame_q = {8'h41};
    send_frame(1'b1);
    d0 = done_cnt;
    @(negedge clk); clr = 1'b1; chk_valid = 1'b1; chk_data = 32'h00420042;
    @(negedge clk); clr = 1'b0; chk_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (done_cnt - d0 != 0) begin n_err++; $display("FAIL clr_vs_chk_done: got %0d want 0", done_cnt - d0); end
    n_cmp++; if (in_ready !== 1'b1 || chk_ready !== 1'b0) begin n_err++; $display("FAIL clr_vs_chk_state: got in_ready=%b chk_ready=%b want 1/0", in_ready, chk_ready); end
  endtask

  task automatic test_single_byte();
    frame_q = {8'h61};
    send_frame(1'b1);
    n_cmp++; if (chk_ready !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL single_wait_chk: got chk_ready=%b in_ready=%b want 1/0", chk_ready, in_ready); end
    send_chk(32'h00620062);
    n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL single_pass: got %b want 1", pass); end
    n_cmp++; if (calc_sum !== 32'h00620062) begin n_err++; $display("FAIL single_calc: got %h want 00620062", calc_sum); end
  endtask

  task automatic test_long_wrap();
    frame_q = {};
    for (int i = 0; i < 1024; i++) frame_q.push_back(8'hFF);
    send_frame(1'b1);
    send_chk(32'h79A6FC2E);
    n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL long_pass: got %b want 1", pass); end
    n_cmp++; if (calc_sum !== 32'h79A6FC2E) begin n_err++; $display("FAIL long_calc: got %h want 79a6fc2e", calc_sum); end
  endtask

  task automatic test_backpressure();
    int d0;
    frame_q = {8'h57, 8'h69, 8'h6B, 8'h69};
    send_frame(1'b0);
    d0 = done_cnt;
    // Checksum offered during ACCUM must be ignored.
    @(negedge clk); chk_valid = 1'b1; chk_data = 32'hDEADBEEF;
    n_cmp++; if (chk_ready !== 1'b0) begin n_err++; $display("FAIL bp_chk_ready_accum: got %b want 0", chk_ready); end
    repeat (2) @(negedge clk);
    chk_valid = 1'b0;
    n_cmp++; if (done_cnt - d0 != 0) begin n_err++; $display("FAIL bp_chk_ignored: got %0d done want 0", done_cnt - d0); end
    frame_q = {8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
    send_frame(1'b1);
    // Byte offered during WAIT_CHK must stall without touching A/B.
    @(negedge clk); in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_wait: got %b want 0", in_ready); end
    repeat (3) @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    send_chk(32'h11E60398);
    n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL bp_pass: got %b want 1", pass); end
    n_cmp++; if (calc_sum !== 32'h11E60398) begin n_err++; $display("FAIL bp_calc: got %h want 11e60398", calc_sum); end
  endtask

  task automatic test_back_to_back();
    frame_q = {8'h61};
    send_frame(1'b1);
    send_chk(32'h00620062);
    n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL b2b_first_pass: got %b want 1", pass); end
    frame_q = {8'h61, 8'h62};
    send_frame(1'b1);
    send_chk(32'h012600C4);
    n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL b2b_second_pass: got %b want 1", pass); end
    n_cmp++; if (calc_sum !== 32'h012600C4) begin n_err++; $display("FAIL b2b_second_calc: got %h want 012600c4", calc_sum); end
  endtask

  task automatic test_async_reset();
    frame_q = {8'h57, 8'h69, 8'h6B, 8'h69};
    send_frame(1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || chk_ready !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL arst_handshake: got in_ready=%b chk_ready=%b done=%b want 1/0/0", in_ready, chk_ready, done); end
    n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL arst_pass: got %b want 0", pass); end
    n_cmp++; if (calc_sum !== 32'h0) begin n_err++; $display("FAIL arst_calc: got %h want 00000000", calc_sum); end
    @(negedge clk); rst_n = 1'b1;
    frame_q = {8'h61};
    send_frame(1'b1);
    send_chk(32'h00620062);
    n_cmp++; if (pass !== 1'b1 || calc_sum !== 32'h00620062) begin n_err++; $display("FAIL arst_restart: got pass=%b calc=%h want 1/00620062", pass, calc_sum); end
`ifdef ADLER_STATUS_CNT_EN
    @(negedge clk);
    n_cmp++; if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0) begin n_err++; $display("FAIL arst_counters: got %0d/%0d want 1/0", pass_cnt, fail_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_wikipedia();
    test_wiki_bad();
    test_clr();
    test_single_byte();
    test_long_wrap();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
